br_fl_ckpt: RTL and testbench

BR_FL_CKPT -- requirements
Module: br_fl_ckpt

---
 rtl/br_fl_ckpt.sv | 101 ++++++++++
 tb/tb_br_fl_ckpt.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/br_fl_ckpt.sv
// Purpose: checkpoints the free-list head pointer for each in-flight branch and
//          returns the oldest one so the free list can be rolled back on a mispredict.
// Latency: push/resolve take effect at the next edge; rc_head_o/rc_vld_o are
//          combinational in the same cycle as the wrong-path resolve.
// Backpressure: a push while full_o is refused; the dispatcher must stall on full_o.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   br_dispatch_en_i   capture fl_cur_head_i as a new checkpoint
//   fl_cur_head_i      current free-list head pointer
//   branch_state_i     resolution of the oldest branch (NONE / CORRECT / WRONG)
//   rc_head_o/rc_vld_o free-list head to restore on a mispredict
//   full_o/empty_o/count_o  occupancy, all taken from registers

`ifndef BR_FL_CKPT_DEFS
`define BR_FL_CKPT_DEFS
`define LRF_IDX_W     6
`define BR_STATE_W    2
`define BR_NONE       2'b00
`define BR_PR_CORRECT 2'b01
`define BR_PR_WRONG   2'b10
`endif

module br_fl_ckpt #(
    parameter int BR_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     br_dispatch_en_i,
    input  logic [`LRF_IDX_W-1:0]    fl_cur_head_i,
    input  logic [`BR_STATE_W-1:0]   branch_state_i,
    output logic [`LRF_IDX_W-1:0]    rc_head_o,
    output logic                     rc_vld_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(BR_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(BR_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [`LRF_IDX_W-1:0] entry_q [BR_DEPTH];
    logic [`LRF_IDX_W-1:0] entry_d [BR_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic full, empty;
    logic mispredict, correct, push;

    always_comb begin
        full       = (count_q == CNT_W'(BR_DEPTH));
        empty      = (count_q == '0);
        // Resolves only act on a non-empty FIFO; undefined encodings do nothing.
        mispredict = (branch_state_i == `BR_PR_WRONG) && !empty;
        correct    = (branch_state_i == `BR_PR_CORRECT) && !empty;
        // A branch dispatching alongside a mispredict is on the wrong path.
        push       = br_dispatch_en_i && !full && !mispredict;

        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                entry_d[tail_q] = fl_cur_head_i;
                tail_d          = tail_q + PTR_W'(1);
            end
            if (correct) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(correct);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rc_vld_o  = mispredict;
    assign rc_head_o = mispredict ? entry_q[head_q] : '0;
    assign full_o    = full;
    assign empty_o   = empty;
    assign count_o   = count_q;

endmodule

// File: tb/tb_br_fl_ckpt.sv
`ifndef BR_FL_CKPT_DEFS
`define BR_FL_CKPT_DEFS
`define LRF_IDX_W     6
`define BR_STATE_W    2
`define BR_NONE       2'b00
`define BR_PR_CORRECT 2'b01
`define BR_PR_WRONG   2'b10
`endif

module tb_br_fl_ckpt;

    localparam int DEPTH = 4;
    localparam logic [1:0] NONE = `BR_NONE;
    localparam logic [1:0] CORR = `BR_PR_CORRECT;
    localparam logic [1:0] WRNG = `BR_PR_WRONG;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   br_dispatch_en_i;
    logic [`LRF_IDX_W-1:0]  fl_cur_head_i;
    logic [`BR_STATE_W-1:0] branch_state_i;
    logic [`LRF_IDX_W-1:0]  rc_head_o;
    logic                   rc_vld_o;
    logic                   full_o;
    logic                   empty_o;
    logic [$clog2(DEPTH):0] count_o;

    br_fl_ckpt #(.BR_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .br_dispatch_en_i (br_dispatch_en_i),
        .fl_cur_head_i    (fl_cur_head_i),
        .branch_state_i   (branch_state_i),
        .rc_head_o        (rc_head_o),
        .rc_vld_o         (rc_vld_o),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        int         hd;
        logic [1:0] st;
        int         exp_vld;   // this cycle
        int         exp_rc;    // this cycle
        int         exp_cnt;   // after the edge
    } vec_t;

    vec_t tbl[$];
    int   model_q[$];   // checkpoints held, oldest first
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic en, input int hd, input logic [1:0] st,
                       input int ev, input int erc, input int ecnt);
        vec_t v;
        v.en = en; v.hd = hd; v.st = st;
        v.exp_vld = ev; v.exp_rc = erc; v.exp_cnt = ecnt;
        tbl.push_back(v);
    endtask

    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic cycle(input logic en, input int hd, input logic [1:0] st,
                         output int got_vld, output int got_rc);
        int  sz;
        bit  wrong_act, corr_act, push_act;
        br_dispatch_en_i = en;
        fl_cur_head_i    = hd[`LRF_IDX_W-1:0];
        branch_state_i   = st;
        #1;
        sz        = model_q.size();
        wrong_act = (st == WRNG) && (sz > 0);
        corr_act  = (st == CORR) && (sz > 0);
        push_act  = en && (sz < DEPTH) && !wrong_act;
        chk("model_count", int'(count_o), sz);
        chk("model_full", int'(full_o), int'(sz == DEPTH));
        chk("model_empty", int'(empty_o), int'(sz == 0));
        chk("model_rc_vld", int'(rc_vld_o), int'(wrong_act));
        chk("model_rc_head", int'(rc_head_o), wrong_act ? model_q[0] : 0);
        got_vld = int'(rc_vld_o);
        got_rc  = int'(rc_head_o);
        if (wrong_act) begin
            model_q.delete();
        end else begin
            if (push_act) model_q.push_back(hd);
            if (corr_act) void'(model_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    int gv, grc;

    initial begin
        rst = 1'b1;
        br_dispatch_en_i = 1'b0;
        fl_cur_head_i = '0;
        branch_state_i = WRNG;
        #2;
        // Outputs in reset, before any clock edge.
        chk("rst_count", int'(count_o), 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_full", int'(full_o), 0);
        chk("rst_rc_vld", int'(rc_vld_o), 0);
        chk("rst_rc_head", int'(rc_head_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        branch_state_i = NONE;

        // Basic push / correct / wrong
        add(1, 3, NONE, 0, 0, 1);
        add(1, 7, NONE, 0, 0, 2);
        add(1, 12, NONE, 0, 0, 3);
        add(0, 0, CORR, 0, 0, 2);
        add(0, 0, WRNG, 1, 7, 0);
        // Fill, overflow push, drain, resolve while empty
        for (int i = 1; i <= 4; i++) add(1, i, NONE, 0, 0, i);
        add(1, 5, NONE, 0, 0, 4);
        for (int i = 3; i >= 0; i--) add(0, 0, CORR, 0, 0, i);
        add(0, 0, WRNG, 0, 0, 0);
        add(0, 0, CORR, 0, 0, 0);
        // Wrap-around
        for (int i = 0; i < 6; i++) begin
            add(1, 20 + i, NONE, 0, 0, 1);
            add(0, 0, CORR, 0, 0, 0);
        end
        add(1, 9, NONE, 0, 0, 1);
        add(1, 10, NONE, 0, 0, 2);
        add(0, 0, WRNG, 1, 9, 0);
        // Push + correct while full: push refused
        for (int i = 1; i <= 4; i++) add(1, 30 + i, NONE, 0, 0, i);
        add(1, 8, CORR, 0, 0, 3);
        add(0, 0, WRNG, 1, 32, 0);
        // Push + correct at count 2: count holds, newest is 8
        add(1, 40, NONE, 0, 0, 1);
        add(1, 41, NONE, 0, 0, 2);
        add(1, 8, CORR, 0, 0, 2);
        add(0, 0, CORR, 0, 0, 1);
        add(0, 0, WRNG, 1, 8, 0);
        // Push + wrong: flush wins, 6 not retained
        add(1, 5, NONE, 0, 0, 1);
        add(1, 6, WRNG, 1, 5, 0);
        add(0, 0, WRNG, 0, 0, 0);
        // Undefined encoding does nothing
        add(1, 13, NONE, 0, 0, 1);
        add(0, 0, 2'b11, 0, 0, 1);
        add(0, 0, WRNG, 1, 13, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].en, tbl[i].hd, tbl[i].st, gv, grc);
            chk($sformatf("vec%0d_rc_vld", i), gv, tbl[i].exp_vld);
            chk($sformatf("vec%0d_rc_head", i), grc, tbl[i].exp_rc);
            chk($sformatf("vec%0d_count", i), int'(count_o), tbl[i].exp_cnt);
            chk($sformatf("vec%0d_full", i), int'(full_o), int'(tbl[i].exp_cnt == DEPTH));
            chk($sformatf("vec%0d_empty", i), int'(empty_o), int'(tbl[i].exp_cnt == 0));
        end

        // Asynchronous reset between edges with three checkpoints held
        cycle(1, 50, NONE, gv, grc);
        cycle(1, 51, NONE, gv, grc);
        cycle(1, 52, NONE, gv, grc);
        chk("pre_arst_count", int'(count_o), 3);
        br_dispatch_en_i = 1'b0;
        branch_state_i = WRNG;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(count_o), 0);
        chk("arst_empty", int'(empty_o), 1);
        chk("arst_full", int'(full_o), 0);
        chk("arst_rc_vld", int'(rc_vld_o), 0);
        chk("arst_rc_head", int'(rc_head_o), 0);
        model_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 11, NONE, gv, grc);
        cycle(0, 0, WRNG, gv, grc);
        chk("post_arst_rc_vld", gv, 1);
        chk("post_arst_rc_head", grc, 11);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            logic [1:0] st;
            int r;
            r = int'($urandom_range(0, 9));
            st = (r < 4) ? NONE : (r < 8) ? CORR : (r < 9) ? WRNG : 2'b11;
            cycle(1'($urandom_range(0, 1) | $urandom_range(0, 1)),
                  int'($urandom_range(0, 63)), st, gv, grc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
